// File: rtl/dma_priority_encoder.sv
// dma_priority_encoder
// --------------------
// Request-resolution block of an 8237A-style DMA controller. It qualifies the
// raw DREQ pins against the mask, software-request and command bits, and picks
// one channel by fixed or rotating priority. The winner is handed to the
// timing control logic as ValidReqID/ReqID and held for the whole service.
// This block also drives the DACK handshake and moves the rotation pointer
// when a service completes.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        asynchronous active-high reset
//   MasterClear  synchronous clear, same effect as reset
//   DREQ[3:0]    raw channel request pins (polarity per CmdDreqLow)
//   MaskBits     1 = channel masked (software requests ignore the mask)
//   SwReq        software request bits
//   CmdDisable   controller disable
//   CmdRotPri    1 = rotating priority, 0 = fixed (channel 0 highest)
//   CmdDreqLow   1 = DREQ pins are active low
//   CmdDackHigh  1 = DACK pins are active high
//   HLDA         hold acknowledge from the CPU
//   SvcDone      one-cycle pulse: service of the current channel ended
//   ValidReqID   a granted request is pending or being serviced
//   ReqID[1:0]   granted channel (meaningful only while ValidReqID=1)
//   DACK[3:0]    channel acknowledge, polarity per CmdDackHigh
//   SwReqClr     one-cycle pulse clearing the serviced channel's SwReq bit

module dma_priority_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       MasterClear,
  input  logic [3:0] DREQ,
  input  logic [3:0] MaskBits,
  input  logic [3:0] SwReq,
  input  logic       CmdDisable,
  input  logic       CmdRotPri,
  input  logic       CmdDreqLow,
  input  logic       CmdDackHigh,
  input  logic       HLDA,
  input  logic       SvcDone,
  output logic       ValidReqID,
  output logic [1:0] ReqID,
  output logic [3:0] DACK,
  output logic [3:0] SwReqClr
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] ACTIVE  = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0] stateReg;
  logic [3:0] sreqReg;
  logic [1:0] lpReg;
  logic [3:0] ackReg;
  logic       validReg;
  logic [1:0] reqIdReg;
  logic [3:0] swReqClrReg;

  logic [3:0] eff;
  logic [1:0] winner;
  logic [1:0] prioBase;
  logic [1:0] cand;

  // Effective request per channel. Software requests bypass the mask but
  // not the controller disable.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gEff
      assign eff[gi] = (((sreqReg[gi] ^ CmdDreqLow) & ~MaskBits[gi]) | SwReq[gi])
                       & ~CmdDisable;
    end
  endgenerate

  // Priority search. Candidates are walked from lowest to highest priority
  // so the last hit (highest priority) wins. In rotating mode the channel
  // just after the last-serviced one (LP+1) is highest; in fixed mode the
  // base is channel 0. The 2-bit add wraps naturally modulo 4.
  always_comb begin
    winner   = 2'd0;
    cand     = 2'd0;
    prioBase = CmdRotPri ? (lpReg + 2'd1) : 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = prioBase + 2'(k);
      if (eff[cand]) begin
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg    <= IDLE;
      sreqReg     <= 4'b0000;
      lpReg       <= 2'd3;
      ackReg      <= 4'b0000;
      validReg    <= 1'b0;
      reqIdReg    <= 2'd0;
      swReqClrReg <= 4'b0000;
    end else if (MasterClear) begin
      stateReg    <= IDLE;
      sreqReg     <= 4'b0000;
      lpReg       <= 2'd3;
      ackReg      <= 4'b0000;
      validReg    <= 1'b0;
      reqIdReg    <= 2'd0;
      swReqClrReg <= 4'b0000;
    end else begin
      sreqReg     <= DREQ;
      swReqClrReg <= 4'b0000;
      case (stateReg)
        IDLE: begin
          if (eff != 4'b0000) begin
            reqIdReg <= winner;
            validReg <= 1'b1;
            stateReg <= REQ;
          end
        end
        REQ: begin
          // The grant is frozen here; a newly arriving higher-priority
          // request cannot preempt it, only a withdrawal can cancel it.
          if (HLDA) begin
            ackReg   <= 4'b0001 << reqIdReg;
            stateReg <= ACTIVE;
          end else if (!eff[reqIdReg]) begin
            validReg <= 1'b0;
            stateReg <= IDLE;
          end
        end
        ACTIVE: begin
          // SvcDone takes precedence over a simultaneous HLDA drop, so a
          // completed service always rotates and clears its SwReq bit.
          if (SvcDone) begin
            ackReg               <= 4'b0000;
            validReg             <= 1'b0;
            swReqClrReg[reqIdReg] <= 1'b1;
            if (CmdRotPri) begin
              lpReg <= reqIdReg;
            end
            stateReg <= RELEASE;
          end else if (!HLDA) begin
            ackReg   <= 4'b0000;
            validReg <= 1'b0;
            stateReg <= RELEASE;
          end
        end
        RELEASE: begin
          // One dead cycle so ValidReqID is low between back-to-back services.
          stateReg <= IDLE;
        end
        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

  assign ValidReqID = validReg;
  assign ReqID      = reqIdReg;
  assign DACK       = CmdDackHigh ? ackReg : ~ackReg;
  assign SwReqClr   = swReqClrReg;

endmodule

// File: tb/tb_dma_priority_encoder.sv
// Scoreboard bench for dma_priority_encoder. Stimulus pushes the events it
// expects (grant, drop, DACK change, SwReqClr pulse) with the cycle they must
// appear in; a monitor on the falling edge detects DUT events and pops them.

module tb_dma_priority_encoder;

  localparam int K_GRANT = 0;
  localparam int K_DROP  = 1;
  localparam int K_DACK  = 2;
  localparam int K_SWCLR = 3;

  typedef struct {
    int         kind;
    logic [3:0] val;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       MasterClear;
  logic [3:0] DREQ;
  logic [3:0] MaskBits;
  logic [3:0] SwReq;
  logic       CmdDisable;
  logic       CmdRotPri;
  logic       CmdDreqLow;
  logic       CmdDackHigh;
  logic       HLDA;
  logic       SvcDone;
  logic       ValidReqID;
  logic [1:0] ReqID;
  logic [3:0] DACK;
  logic [3:0] SwReqClr;

  exp_t       expq[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic       prevValid = 1'b0;
  logic [3:0] prevDack = 4'bxxxx;

  dma_priority_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .MasterClear(MasterClear),
    .DREQ       (DREQ),
    .MaskBits   (MaskBits),
    .SwReq      (SwReq),
    .CmdDisable (CmdDisable),
    .CmdRotPri  (CmdRotPri),
    .CmdDreqLow (CmdDreqLow),
    .CmdDackHigh(CmdDackHigh),
    .HLDA       (HLDA),
    .SvcDone    (SvcDone),
    .ValidReqID (ValidReqID),
    .ReqID      (ReqID),
    .DACK       (DACK),
    .SwReqClr   (SwReqClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic string kname(input int kind);
    case (kind)
      K_GRANT: kname = "grant";
      K_DROP:  kname = "drop";
      K_DACK:  kname = "dack";
      default: kname = "swclr";
    endcase
  endfunction

  function automatic logic [3:0] oh(input int ch);
    logic [3:0] one;
    one = 4'b0001;
    oh = one << ch;
  endfunction

  task automatic want(input int kind, input logic [3:0] val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    expq.push_back(e);
  endtask

  task automatic check(input int kind, input logic [3:0] val);
    exp_t e;
    vectors++;
    if (expq.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected %s: got %b at cycle %0d, nothing expected", kname(kind), val, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.val !== val || (e.cyc >= 0 && e.cyc != cyc)) begin
        miscompares++;
        $display("FAIL %s: got %s=%b at cycle %0d, expected %s=%b at cycle %0d",
                 kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
      end else begin
        $display("ok   %s=%b at cycle %0d", kname(kind), val, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (ValidReqID && !prevValid) check(K_GRANT, {2'b00, ReqID});
    if (!ValidReqID && prevValid) check(K_DROP, 4'b0000);
    if (DACK !== prevDack) check(K_DACK, DACK);
    if (SwReqClr != 4'b0000) check(K_SWCLR, SwReqClr);
    prevValid = ValidReqID;
    prevDack  = DACK;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wantDone(input logic [3:0] sw, input logic [3:0] dackIdle, input int c);
    want(K_DROP, 4'b0000, c);
    want(K_DACK, dackIdle, c);
    want(K_SWCLR, sw, c);
  endtask

  int seq[5] = '{0, 1, 2, 3, 0};
  int base;

  initial begin
    reset = 1'b1; MasterClear = 1'b0; DREQ = 4'b0; MaskBits = 4'b0; SwReq = 4'b0;
    CmdDisable = 1'b0; CmdRotPri = 1'b0; CmdDreqLow = 1'b0; CmdDackHigh = 1'b0;
    HLDA = 1'b0; SvcDone = 1'b0;
    want(K_DACK, 4'b1111, -1);
    tick(3);
    reset = 1'b0;
    tick(2);

    // Fixed priority, two-cycle latency, DACK only after HLDA.
    DREQ = 4'b0110;
    want(K_GRANT, 4'd1, cyc + 2);
    tick(4);
    HLDA = 1'b1;
    want(K_DACK, 4'b1101, cyc + 1);
    tick(2);
    SvcDone = 1'b1; DREQ = 4'b0000;
    wantDone(4'b0010, 4'b1111, cyc + 1);
    tick(1);
    SvcDone = 1'b0; HLDA = 1'b0;
    tick(3);

    // Rotating priority, all channels requesting: 0,1,2,3,0 with a gap each.
    CmdRotPri = 1'b1; DREQ = 4'b1111; HLDA = 1'b1;
    base = cyc;
    for (int k = 0; k < 5; k++) begin
      want(K_GRANT, 4'(seq[k]), base + 2 + 4 * k);
      want(K_DACK, ~oh(seq[k]), base + 3 + 4 * k);
      wantDone(oh(seq[k]), 4'b1111, base + 4 + 4 * k);
    end
    tick(3);
    for (int k = 0; k < 5; k++) begin
      SvcDone = 1'b1;
      if (k == 4) begin
        DREQ = 4'b0000;
        HLDA = 1'b0;   // simultaneous HLDA drop still counts as completion
      end
      tick(1);
      SvcDone = 1'b0;
      tick(3);
    end
    CmdRotPri = 1'b0;

    // Software request bypasses the mask; SwReqClr is a single-cycle pulse.
    MaskBits = 4'b0001; SwReq = 4'b0001; HLDA = 1'b1;
    want(K_GRANT, 4'd0, cyc + 1);
    want(K_DACK, 4'b1110, cyc + 2);
    tick(2);
    SvcDone = 1'b1; SwReq = 4'b0000;
    wantDone(4'b0001, 4'b1111, cyc + 1);
    tick(1);
    SvcDone = 1'b0; HLDA = 1'b0; MaskBits = 4'b0000;
    tick(3);

    // Active-low DREQ, active-high DACK; disable blocks grants in IDLE and
    // neither disable nor mask disturbs an active service.
    CmdDisable = 1'b1; DREQ = 4'b1011; CmdDreqLow = 1'b1; CmdDackHigh = 1'b1;
    want(K_DACK, 4'b0000, cyc);
    tick(3);
    CmdDisable = 1'b0; HLDA = 1'b1;
    want(K_GRANT, 4'd2, cyc + 1);
    want(K_DACK, 4'b0100, cyc + 2);
    tick(2);
    MaskBits = 4'b0100; CmdDisable = 1'b1;
    tick(3);
    SvcDone = 1'b1; DREQ = 4'b1111;
    wantDone(4'b0100, 4'b0000, cyc + 1);
    tick(1);
    SvcDone = 1'b0; HLDA = 1'b0;
    tick(1);
    DREQ = 4'b0000; CmdDreqLow = 1'b0; CmdDackHigh = 1'b0; MaskBits = 4'b0000;
    want(K_DACK, 4'b1111, cyc);
    tick(3);
    CmdDisable = 1'b0;
    tick(2);

    // Rotating with LP=0: no preemption in REQ, withdrawal keeps LP.
    CmdRotPri = 1'b1; DREQ = 4'b0100;
    want(K_GRANT, 4'd2, cyc + 2);
    tick(3);
    DREQ = 4'b0111;
    tick(3);
    DREQ = 4'b0000;
    want(K_DROP, 4'b0000, cyc + 2);
    tick(3);
    DREQ = 4'b1011;               // LP=0 -> order 1,2,3,0 -> 1
    want(K_GRANT, 4'd1, cyc + 2);
    tick(3);
    HLDA = 1'b1;
    want(K_DACK, 4'b1101, cyc + 1);
    tick(2);
    HLDA = 1'b0;                  // HLDA loss: no SwReqClr, no LP update
    want(K_DROP, 4'b0000, cyc + 1);
    want(K_DACK, 4'b1111, cyc + 1);
    want(K_GRANT, 4'd1, cyc + 3);
    tick(4);
    HLDA = 1'b1;
    want(K_DACK, 4'b1101, cyc + 1);
    tick(2);
    HLDA = 1'b0; SvcDone = 1'b1;  // LP becomes 1 -> order 2,3,0,1 -> 3
    wantDone(4'b0010, 4'b1111, cyc + 1);
    want(K_GRANT, 4'd3, cyc + 3);
    tick(1);
    SvcDone = 1'b0;
    tick(3);
    HLDA = 1'b1;
    want(K_DACK, 4'b0111, cyc + 1);
    tick(2);

    // Async reset mid-service: immediate release, LP back to 3.
    reset = 1'b1;
    want(K_DROP, 4'b0000, cyc);
    want(K_DACK, 4'b1111, cyc);
    tick(2);
    reset = 1'b0;
    want(K_GRANT, 4'd0, cyc + 2);
    want(K_DACK, 4'b1110, cyc + 3);
    tick(3);
    SvcDone = 1'b1;               // LP becomes 0 -> next grant is 1
    wantDone(4'b0001, 4'b1111, cyc + 1);
    want(K_GRANT, 4'd1, cyc + 3);
    want(K_DACK, 4'b1101, cyc + 4);
    tick(1);
    SvcDone = 1'b0;
    tick(3);

    // MasterClear mid-service: release on the next edge, LP back to 3.
    MasterClear = 1'b1;
    want(K_DROP, 4'b0000, cyc + 1);
    want(K_DACK, 4'b1111, cyc + 1);
    tick(1);
    MasterClear = 1'b0;
    want(K_GRANT, 4'd0, cyc + 2);
    want(K_DACK, 4'b1110, cyc + 3);
    tick(4);
    SvcDone = 1'b1; DREQ = 4'b0000; HLDA = 1'b0;
    wantDone(4'b0001, 4'b1111, cyc + 1);
    tick(1);
    SvcDone = 1'b0;
    tick(4);

    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL pending events: got %0d still queued, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
